// File: rtl/twi_bus_ctrl.sv
// twi_bus_ctrl: memory-mapped front end for twi_master on the SchoolMIPS data bus.
// It holds the transfer registers and launches one write or read per CPU command.
// A watchdog aborts any transaction that never sees its tr completion pulse.
module twi_bus_ctrl #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 200000,
    parameter int CNT_W   = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_we,
    input  logic [31:0]       bus_wd,
    output logic [31:0]       bus_rd,
    output logic              irq,
    output logic [6:0]        chip_addr,
    output logic [7:0]        reg_addr,
    output logic [7:0]        datain,
    input  logic [7:0]        dataout,
    output logic              wr,
    output logic              rd,
    input  logic              tr,
    output logic              tr_clr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       chip_q, chip_d;
    logic [7:0]       reg_q, reg_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             ie_q, ie_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             irq_q, irq_d;
    logic             cmd_rd_q, cmd_rd_d;
    logic             wr_q, wr_d;
    logic             rd_q, rd_d;
    logic             tr_clr_q, tr_clr_d;
    logic [CNT_W-1:0] wd_q, wd_d;

    logic [1:0]       reg_sel;
    logic             ctrl_wr;
    logic             start_cmd;
    logic             set_done;
    logic             busy;
    logic             unused_bits;

    assign reg_sel     = bus_addr[3:2];
    assign ctrl_wr     = bus_we && (reg_sel == 2'd3);
    assign start_cmd   = ctrl_wr && (bus_wd[0] || bus_wd[1]);
    assign busy        = (state_q != IDLE);
    assign unused_bits = ^{bus_wd[31:8], bus_addr[1:0]};

    assign chip_addr = chip_q;
    assign reg_addr  = reg_q;
    assign datain    = wdata_q;
    assign wr        = wr_q;
    assign rd        = rd_q;
    assign tr_clr    = tr_clr_q;
    assign irq       = irq_q;

    // Read mux: register contents returned combinationally for the addressed word.
    always_comb begin
        bus_rd = 32'd0;
        case (reg_sel)
            2'd0:    bus_rd = {25'd0, chip_q};
            2'd1:    bus_rd = {24'd0, reg_q};
            2'd2:    bus_rd = {24'd0, wdata_q};
            default: bus_rd = {16'd0, rdata_q, 4'd0, ie_q, timeout_q, done_q, busy};
        endcase
    end

    // Next-state logic: register writes, transaction sequencing, watchdog and status.
    always_comb begin
        state_d   = state_q;
        chip_d    = chip_q;
        reg_d     = reg_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ie_d      = ie_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        cmd_rd_d  = cmd_rd_q;
        wd_d      = wd_q;
        set_done  = 1'b0;

        // Address registers are frozen while a transfer is in flight.
        if (bus_we && !busy) begin
            case (reg_sel)
                2'd0:    chip_d  = bus_wd[6:0];
                2'd1:    reg_d   = bus_wd[7:0];
                2'd2:    wdata_d = bus_wd[7:0];
                default: ;
            endcase
        end

        if (ctrl_wr) begin
            ie_d = bus_wd[2];
        end

        case (state_q)
            IDLE: begin
                if (start_cmd) begin
                    state_d   = ISSUE;
                    cmd_rd_d  = !bus_wd[0];
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    wd_d      = '0;
                end
            end
            ISSUE: begin
                state_d = BUSY;
            end
            BUSY: begin
                wd_d = wd_q + CNT_W'(1);
                if (tr) begin
                    if (cmd_rd_q) begin
                        rdata_d = dataout;
                    end
                    set_done = 1'b1;
                    state_d  = IDLE;
                end else if (wd_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ABORT;
                    wd_d    = '0;
                end
            end
            default: begin
                wd_d = wd_q + CNT_W'(1);
                if (wd_q == CNT_W'(3)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                    set_done  = 1'b1;
                end
            end
        endcase

        if (set_done) begin
            done_d = 1'b1;
        end else if (ctrl_wr && bus_wd[3]) begin
            done_d = 1'b0;
        end

        irq_d    = done_q && ie_q;
        wr_d     = (state_d == BUSY) && !cmd_rd_q;
        rd_d     = (state_d == BUSY) && cmd_rd_q;
        tr_clr_d = !((state_d == ISSUE) || (state_d == BUSY));
    end

    // State and register storage with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            chip_q    <= '0;
            reg_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ie_q      <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            irq_q     <= 1'b0;
            cmd_rd_q  <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            tr_clr_q  <= 1'b1;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            chip_q    <= chip_d;
            reg_q     <= reg_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ie_q      <= ie_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            irq_q     <= irq_d;
            cmd_rd_q  <= cmd_rd_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            tr_clr_q  <= tr_clr_d;
            wd_q      <= wd_d;
        end
    end

endmodule

// File: tb/tb_twi_bus_ctrl.sv
// Directed testbench for twi_bus_ctrl with a short watchdog (TIMEOUT = 50).
module tb_twi_bus_ctrl;

    localparam int TO = 50;

    logic        clk;
    logic        rst;
    logic [3:0]  bus_addr;
    logic        bus_we;
    logic [31:0] bus_wd;
    logic [31:0] bus_rd;
    logic        irq;
    logic [6:0]  chip_addr;
    logic [7:0]  reg_addr;
    logic [7:0]  datain;
    logic [7:0]  dataout;
    logic        wr;
    logic        rd;
    logic        tr;
    logic        tr_clr;

    int checks = 0;
    int errors = 0;

    twi_bus_ctrl #(.ADDR_W(4), .TIMEOUT(TO), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_addr  (bus_addr),
        .bus_we    (bus_we),
        .bus_wd    (bus_wd),
        .bus_rd    (bus_rd),
        .irq       (irq),
        .chip_addr (chip_addr),
        .reg_addr  (reg_addr),
        .datain    (datain),
        .dataout   (dataout),
        .wr        (wr),
        .rd        (rd),
        .tr        (tr),
        .tr_clr    (tr_clr)
    );

    // Free-running clock, period 20.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One-cycle bus write, issued from a falling edge.
    task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data);
        bus_addr = addr;
        bus_wd   = data;
        bus_we   = 1'b1;
        @(negedge clk);
        bus_we   = 1'b0;
        bus_wd   = 32'd0;
    endtask

    // Combinational register read followed by a comparison.
    task automatic checkReg(input string tag, input logic [3:0] addr, input logic [31:0] expected);
        bus_addr = addr;
        #1;
        checkOutput(tag, bus_rd, expected);
    endtask

    // One-cycle tr completion pulse carrying a read byte.
    task automatic pulseTr(input logic [7:0] data);
        dataout = data;
        tr      = 1'b1;
        @(negedge clk);
        tr      = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        bus_addr = 4'd0;
        bus_we   = 1'b0;
        bus_wd   = 32'd0;
        dataout  = 8'd0;
        tr       = 1'b0;

        // Power-on reset values.
        repeat (2) @(negedge clk);
        checkOutput("por_wr", {31'd0, wr}, 32'd0);
        checkOutput("por_tr_clr", {31'd0, tr_clr}, 32'd1);
        checkOutput("por_irq", {31'd0, irq}, 32'd0);
        checkReg("por_stat", 4'hC, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Write transfer.
        $display("[TB] write transfer");
        applyStimulus(4'h0, 32'h50);
        applyStimulus(4'h4, 32'h12);
        applyStimulus(4'h8, 32'hA5);
        checkOutput("chip_addr", {25'd0, chip_addr}, 32'h50);
        checkOutput("reg_addr", {24'd0, reg_addr}, 32'h12);
        checkOutput("datain", {24'd0, datain}, 32'hA5);
        checkReg("chip_read", 4'h0, 32'h50);
        applyStimulus(4'hC, 32'h1);
        checkOutput("issue_wr_low", {31'd0, wr}, 32'd0);
        checkOutput("issue_tr_clr", {31'd0, tr_clr}, 32'd0);
        @(negedge clk);
        checkOutput("busy_wr", {31'd0, wr}, 32'd1);
        checkOutput("busy_rd", {31'd0, rd}, 32'd0);
        checkReg("busy_stat", 4'hC, 32'h0001);
        pulseTr(8'h77);
        checkOutput("wr_drop", {31'd0, wr}, 32'd0);
        checkOutput("end_tr_clr", {31'd0, tr_clr}, 32'd1);
        checkReg("write_stat", 4'hC, 32'h0002);

        // Busy protection: register and start writes ignored during BUSY.
        $display("[TB] busy protection");
        applyStimulus(4'hC, 32'h1);
        @(negedge clk);
        applyStimulus(4'h0, 32'h7F);
        applyStimulus(4'hC, 32'h2);
        checkOutput("prot_chip", {25'd0, chip_addr}, 32'h50);
        checkOutput("prot_rd", {31'd0, rd}, 32'd0);
        checkOutput("prot_wr", {31'd0, wr}, 32'd1);
        pulseTr(8'h11);
        checkReg("prot_stat", 4'hC, 32'h0002);

        // Read transfer with interrupt.
        $display("[TB] read transfer");
        applyStimulus(4'hC, 32'hC);
        checkReg("ie_stat", 4'hC, 32'h0008);
        applyStimulus(4'hC, 32'h6);
        @(negedge clk);
        checkOutput("read_rd", {31'd0, rd}, 32'd1);
        checkOutput("read_wr", {31'd0, wr}, 32'd0);
        pulseTr(8'h3C);
        checkReg("read_stat", 4'hC, 32'h3C0A);
        checkOutput("irq_lag", {31'd0, irq}, 32'd0);
        checkOutput("rd_drop", {31'd0, rd}, 32'd0);
        @(negedge clk);
        checkOutput("irq_set", {31'd0, irq}, 32'd1);
        applyStimulus(4'hC, 32'hC);
        checkReg("clr_stat", 4'hC, 32'h3C08);
        @(negedge clk);
        checkOutput("irq_clr", {31'd0, irq}, 32'd0);

        // Race: tr on the last watchdog cycle wins over the timeout.
        $display("[TB] tr vs watchdog race");
        applyStimulus(4'hC, 32'h1);
        @(negedge clk);
        repeat (TO - 1) @(negedge clk);
        checkOutput("race_wr", {31'd0, wr}, 32'd1);
        pulseTr(8'h99);
        checkReg("race_stat", 4'hC, 32'h3C02);

        // Timeout with both start bits set: write wins, then abort.
        $display("[TB] timeout");
        applyStimulus(4'hC, 32'h3);
        @(negedge clk);
        checkOutput("both_wr", {31'd0, wr}, 32'd1);
        checkOutput("both_rd", {31'd0, rd}, 32'd0);
        repeat (TO - 1) @(negedge clk);
        checkOutput("last_busy_tr_clr", {31'd0, tr_clr}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("abort_tr_clr_%0d", i), {31'd0, tr_clr}, 32'd1);
            checkOutput($sformatf("abort_wr_%0d", i), {31'd0, wr}, 32'd0);
            checkReg($sformatf("abort_stat_%0d", i), 4'hC, 32'h3C01);
        end
        @(negedge clk);
        checkReg("timeout_stat", 4'hC, 32'h3C06);

        // Asynchronous reset in the middle of a transfer.
        $display("[TB] reset mid-busy");
        applyStimulus(4'hC, 32'h1);
        @(negedge clk);
        checkOutput("pre_reset_wr", {31'd0, wr}, 32'd1);
        rst = 1'b0;
        #2;
        checkOutput("rst_wr", {31'd0, wr}, 32'd0);
        checkOutput("rst_rd", {31'd0, rd}, 32'd0);
        checkOutput("rst_tr_clr", {31'd0, tr_clr}, 32'd1);
        checkOutput("rst_irq", {31'd0, irq}, 32'd0);
        checkReg("rst_chip", 4'h0, 32'd0);
        checkReg("rst_reg", 4'h4, 32'd0);
        checkReg("rst_wdata", 4'h8, 32'd0);
        checkReg("rst_stat", 4'hC, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
